// File: rtl/aut_pkg.sv
// Shared types and constants for the access-control stage.
package aut_pkg;

  localparam int AUT_W      = 3;
  localparam int CODE_W_DEF = 6;

  localparam logic [AUT_W-1:0] LVL_HI  = 3'b100;
  localparam logic [AUT_W-1:0] LVL_MID = 3'b010;
  localparam logic [AUT_W-1:0] LVL_LO  = 3'b001;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EVAL  = 3'd1,
    GRANT = 3'd2,
    DENY  = 3'd3,
    LOCK  = 3'd4
  } aut_state_t;

  // Highest set bit of the comparator result, as a one-hot level.
  function automatic logic [AUT_W-1:0] aut_level(input logic [AUT_W-1:0] aut);
    logic [AUT_W-1:0] lvl;
    if (aut[2]) begin
      lvl = LVL_HI;
    end else if (aut[1]) begin
      lvl = LVL_MID;
    end else if (aut[0]) begin
      lvl = LVL_LO;
    end else begin
      lvl = 3'b000;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/aut_timer.sv
// Loadable down-counter shared by the GRANT and LOCK windows.
// Counts down to zero and then holds; zero flags the final cycle of a window.
module aut_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/aut_access_controller.sv
// Access-control stage downstream of the authentication comparator.
// Optional lockout is built when AUT_LOCKOUT_EN is defined; otherwise locked is tied low.
module aut_access_controller
  import aut_pkg::*;
#(
  parameter int CODE_W       = CODE_W_DEF,
  parameter int GRANT_CYCLES = 100,
  parameter int FAIL_LIMIT   = 3,
  parameter int LOCK_CYCLES  = 200
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CODE_W-1:0]               code_in,
  input  logic                            submit,
  input  logic [AUT_W-1:0]                aut_in,
  output logic [CODE_W-1:0]               code_out,
  output logic                            grant,
  output logic [AUT_W-1:0]                access_level,
  output logic                            denied,
  output logic                            locked,
  output logic [$clog2(FAIL_LIMIT+1)-1:0] fail_cnt,
  output logic                            busy
);

  localparam int FCW  = $clog2(FAIL_LIMIT+1);
  localparam int TMAX = (GRANT_CYCLES > LOCK_CYCLES) ? GRANT_CYCLES : LOCK_CYCLES;
  localparam int TW   = $clog2(TMAX+1);

  localparam logic [FCW-1:0] FAIL_MAX  = FCW'(FAIL_LIMIT);
  localparam logic [TW-1:0]  GRANT_LD  = TW'(GRANT_CYCLES - 1);
`ifdef AUT_LOCKOUT_EN
  localparam logic [TW-1:0]  LOCK_LD   = TW'(LOCK_CYCLES - 1);
`endif

  aut_state_t       state_q, state_d;
  logic             submit_q;
  logic [CODE_W-1:0] code_q, code_d;
  logic             grant_q, grant_d;
  logic [AUT_W-1:0] level_q, level_d;
  logic             denied_q, denied_d;
  logic [FCW-1:0]   fail_q, fail_d;
  logic             busy_q, busy_d;
`ifdef AUT_LOCKOUT_EN
  logic             locked_q, locked_d;
`endif

  logic             submit_evt;
  logic [FCW-1:0]   fail_inc;
  logic             tmr_load;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;

  assign submit_evt = submit & ~submit_q;
  assign fail_inc   = (fail_q == FAIL_MAX) ? fail_q : fail_q + {{(FCW-1){1'b0}}, 1'b1};

  aut_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    grant_d  = grant_q;
    level_d  = level_q;
    denied_d = denied_q;
    fail_d   = fail_q;
    tmr_load = 1'b0;
    tmr_val  = {TW{1'b0}};
`ifdef AUT_LOCKOUT_EN
    locked_d = locked_q;
`endif
    case (state_q)
      IDLE: begin
        if (submit_evt) begin
          code_d  = code_in;
          state_d = EVAL;
        end else begin
          state_d = IDLE;
        end
      end
      EVAL: begin
        if (aut_in != 3'b000) begin
          state_d  = GRANT;
          grant_d  = 1'b1;
          level_d  = aut_level(aut_in);
          fail_d   = {FCW{1'b0}};
          tmr_load = 1'b1;
          tmr_val  = GRANT_LD;
        end else begin
          fail_d = fail_inc;
`ifdef AUT_LOCKOUT_EN
          if (fail_inc == FAIL_MAX) begin
            state_d  = LOCK;
            locked_d = 1'b1;
            denied_d = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = LOCK_LD;
          end else begin
            state_d  = DENY;
            denied_d = 1'b1;
          end
`else
          state_d  = DENY;
          denied_d = 1'b1;
`endif
        end
      end
      GRANT: begin
        if (tmr_zero) begin
          state_d = IDLE;
          grant_d = 1'b0;
          level_d = 3'b000;
        end else begin
          state_d = GRANT;
        end
      end
      DENY: begin
        denied_d = 1'b0;
        state_d  = IDLE;
      end
      LOCK: begin
`ifdef AUT_LOCKOUT_EN
        // denied was pulsed on entry; the lock window itself keeps it low.
        denied_d = 1'b0;
        if (tmr_zero) begin
          state_d  = IDLE;
          locked_d = 1'b0;
          fail_d   = {FCW{1'b0}};
        end else begin
          state_d = LOCK;
        end
`else
        state_d = IDLE;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      submit_q <= 1'b0;
      code_q   <= {CODE_W{1'b0}};
      grant_q  <= 1'b0;
      level_q  <= 3'b000;
      denied_q <= 1'b0;
      fail_q   <= {FCW{1'b0}};
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      submit_q <= submit;
      code_q   <= code_d;
      grant_q  <= grant_d;
      level_q  <= level_d;
      denied_q <= denied_d;
      fail_q   <= fail_d;
      busy_q   <= busy_d;
    end
  end

`ifdef AUT_LOCKOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= 1'b0;
    end else begin
      locked_q <= locked_d;
    end
  end
  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  assign code_out     = code_q;
  assign grant        = grant_q;
  assign access_level = level_q;
  assign denied       = denied_q;
  assign fail_cnt     = fail_q;
  assign busy         = busy_q;

endmodule
